tiger_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of tiger_decode.
- Holds the fetch PC and issues one request at a time to the instruction memory/I-cache over a req/gnt/rvalid handshake.
- Registers the returned word as `instr` for decode and takes the next fetch address from decode's `nextpc`.
- Handles decode `stall`/`clear`, discards in-flight responses after a redirect, and saves/restores PC for checkpoint/rollback.

---
 rtl/tiger_fetch_pkg.sv | 19 +
 rtl/tiger_fetch.sv | 141 ++++++++++++++
 tb/tb_tiger_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiger_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings, NOP constant, helpers.
// Imported by tiger_fetch.
package tiger_fetch_pkg;

    typedef enum logic [1:0] {
        FS_ISSUE = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD_C = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/tiger_fetch.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch, held for decode.
// Define TIGER_FETCH_CKPT_EN to enable the pc_b checkpoint/rollback register.
module tiger_fetch
    import tiger_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clear,
    input  logic [31:0] nextpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pcDe,
    input  logic        poweron,
    input  logic        checkpointdone
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [31:0]  pcde_q, pcde_d;
    logic [31:0]  npc;

    assign npc = word_align(nextpc);

`ifdef TIGER_FETCH_CKPT_EN
    logic [31:0] pcb_q, pcb_d;
    logic        busy;

    // A request is still owed a response after this edge
    assign busy = ((state_q == FS_WAIT || state_q == FS_DRAIN) && !imem_rvalid)
               || (state_q == FS_ISSUE && imem_gnt);
`else
    logic unused_ckpt;
    assign unused_ckpt = poweron ^ checkpointdone;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pcde_d  = pcde_q;
`ifdef TIGER_FETCH_CKPT_EN
        pcb_d   = pcb_q;
`endif
        unique case (state_q)
            FS_ISSUE: begin
                if (imem_gnt) begin
                    state_d = clear ? FS_DRAIN : FS_WAIT;
                end
                if (clear) begin
                    pc_d = npc;
                end
            end
            FS_WAIT: begin
                if (clear) begin
                    pc_d    = npc;
                    valid_d = 1'b0;
                    state_d = imem_rvalid ? FS_ISSUE : FS_DRAIN;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    pcde_d  = pc_q;
                    valid_d = 1'b1;
                    state_d = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (clear || !stall) begin
                    pc_d    = npc;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    state_d = FS_ISSUE;
                end
            end
            FS_DRAIN: begin
                if (clear) begin
                    pc_d = npc;
                end
                if (imem_rvalid) begin
                    state_d = FS_ISSUE;
                end
            end
            default: state_d = FS_ISSUE;
        endcase
`ifdef TIGER_FETCH_CKPT_EN
        if (checkpointdone) begin
            pcb_d = valid_q ? pcde_q : pc_q;
        end else if (poweron) begin
            pc_d    = pcb_q;
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pcde_d  = pcde_q;
            state_d = busy ? FS_DRAIN : FS_ISSUE;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FS_ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            pcde_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pcde_q  <= pcde_d;
        end
    end

`ifdef TIGER_FETCH_CKPT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcb_q <= 32'h0;
        end else begin
            pcb_q <= pcb_d;
        end
    end
`endif

    // Request is suppressed while reset is held even though state is ISSUE
    assign imem_req   = (state_q == FS_ISSUE) && !reset;
    assign imem_addr  = word_align(pc_q);
    assign instr      = instr_q;
    assign instrValid = valid_q;
    assign pcDe       = pcde_q;

endmodule

// File: tb/tb_tiger_fetch.sv
// Self-checking bench for tiger_fetch: directed plan plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_tiger_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, clear;
    logic [31:0] nextpc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr, pcDe;
    logic        instrValid;
    logic        poweron, checkpointdone;

    int checks = 0;
    int errors = 0;

    // Model: next address, whether a response is owed, whether it is dead,
    // and whether a word is held for decode.
    logic [31:0] m_pc, m_instr, m_pcde, m_pcb, m_gaddr;
    bit          m_out, m_disc, m_have;

    always #5 clk = ~clk;

    tiger_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .clear          (clear),
        .nextpc         (nextpc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instrValid     (instrValid),
        .pcDe           (pcDe),
        .poweron        (poweron),
        .checkpointdone (checkpointdone)
    );

    function automatic logic [31:0] wordof(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pcde = 32'h0; m_pcb = 32'h0;
        m_out = 0; m_disc = 0; m_have = 0; m_gaddr = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] np;
        bit busy;
        np = {nextpc[31:2], 2'b00};
        if (reset) begin
            model_reset();
            return;
        end
`ifdef TIGER_FETCH_CKPT_EN
        if (checkpointdone) begin
            m_pcb = m_have ? m_pcde : m_pc;
        end else if (poweron) begin
            busy = (m_out && !imem_rvalid) || (!m_out && !m_have && imem_gnt);
            if (!m_out && !m_have && imem_gnt) m_gaddr = m_pc;
            m_pc = m_pcb; m_have = 0; m_instr = NOP;
            m_out = busy; m_disc = busy;
            return;
        end
`endif
        busy = 0;
        if (!m_out && !m_have) begin
            if (imem_gnt) begin
                m_out = 1; m_disc = clear; m_gaddr = m_pc;
            end
            if (clear) m_pc = np;
        end else if (m_out) begin
            if (imem_rvalid) begin
                m_out = 0;
                if (!m_disc && !clear) begin
                    m_have = 1; m_instr = imem_rdata; m_pcde = m_pc;
                end
            end else if (clear) begin
                m_disc = 1;
            end
            if (clear) m_pc = np;
        end else if (clear || !stall) begin
            m_pc = np; m_have = 0; m_instr = NOP;
        end
    endtask

    task automatic compare();
        chk1("req", imem_req, !reset && !m_out && !m_have);
        chk("addr", imem_addr, m_pc);
        chk("instr", instr, m_instr);
        chk1("valid", instrValid, m_have);
        chk("pcDe", pcDe, m_pcde);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // Assert reset between edges, hold it across one edge, release it.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instrValid, 1'b0);
        chk("rst_instr", instr, NOP);
        chk("rst_pcDe", pcDe, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        step();
        reset = 1'b0;
        #1;
    endtask

    logic [31:0] words [4] = '{32'h1111_0001, 32'h2222_0002,
                               32'h3333_0003, 32'h2402_0005};

    initial begin
        reset = 1'b1; stall = 0; clear = 0; nextpc = 32'h0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
        poweron = 0; checkpointdone = 0;
        model_reset();
        repeat (2) step();
        chk1("reset_req", imem_req, 1'b0);
        chk1("reset_valid", instrValid, 1'b0);
        reset = 1'b0;
        #1;

        // zero-wait memory: one instruction per three cycles
        for (int i = 0; i < 4; i++) begin
            chk("zw_addr", imem_addr, 32'(i * 4));
            chk1("zw_req", imem_req, 1'b1);
            imem_gnt = 1; step();
            imem_gnt = 0; imem_rvalid = 1; imem_rdata = words[i]; step();
            imem_rvalid = 0;
            chk("zw_instr", instr, words[i]);
            chk1("zw_valid", instrValid, 1'b1);
            chk("zw_pcDe", pcDe, 32'(i * 4));
            if (i < 3) begin
                nextpc = 32'(i * 4 + 4); step();
            end
        end

        // stall in HOLD
        stall = 1; nextpc = 32'h0000_0999;
        repeat (4) begin
            step();
            chk("st_instr", instr, 32'h2402_0005);
            chk("st_pcDe", pcDe, 32'h0000_000C);
            chk1("st_req", imem_req, 1'b0);
        end
        stall = 0; nextpc = 32'h0000_0010; step();
        chk("st_addr", imem_addr, 32'h0000_0010);
        chk1("st_req2", imem_req, 1'b1);

        // clear in WAIT, late response discarded
        imem_gnt = 1; step();
        imem_gnt = 0; clear = 1; nextpc = 32'h0000_0180; step();
        clear = 0; step();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
        imem_rvalid = 0;
        chk1("cw_valid", instrValid, 1'b0);
        chk("cw_instr", instr, NOP);
        chk("cw_addr", imem_addr, 32'h0000_0180);
        step();
        chk1("cw_valid2", instrValid, 1'b0);

        // grant withheld, then redirect while still requesting
        repeat (5) begin
            step();
            chk1("gw_req", imem_req, 1'b1);
            chk("gw_addr", imem_addr, 32'h0000_0180);
        end
        clear = 1; nextpc = 32'h0000_0040; step();
        clear = 0;
        chk("gw_addr2", imem_addr, 32'h0000_0040);

        // reset mid-WAIT, stale rvalid afterwards
        imem_gnt = 1; step();
        imem_gnt = 0;
        pulse_reset();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
        imem_rvalid = 0;
        chk1("rw_valid", instrValid, 1'b0);
        chk("rw_addr", imem_addr, 32'h0);
        chk1("rw_req", imem_req, 1'b1);

        // checkpoint then rollback through a drain
        clear = 1; nextpc = 32'h0000_0100; step();
        clear = 0; imem_gnt = 1; step();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678; step();
        imem_rvalid = 0;
        chk("ck_pcDe", pcDe, 32'h0000_0100);
        checkpointdone = 1; stall = 1; step();
        checkpointdone = 0; stall = 0; nextpc = 32'h0000_0200; step();
        chk("ck_addr", imem_addr, 32'h0000_0200);
        imem_gnt = 1; step();
        imem_gnt = 0; poweron = 1; step();
        poweron = 0;
`ifdef TIGER_FETCH_CKPT_EN
        chk1("po_req_drain", imem_req, 1'b0);
`endif
        imem_rvalid = 1; imem_rdata = 32'hCAFE_F00D; step();
        imem_rvalid = 0;
`ifdef TIGER_FETCH_CKPT_EN
        chk("po_addr", imem_addr, 32'h0000_0100);
        chk1("po_valid", instrValid, 1'b0);
`endif
        nextpc = m_pcde + 32'd4; step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            stall = ($urandom % 3) == 0;
            clear = ($urandom % 7) == 0;
            nextpc = (($urandom % 2) == 0) ? m_pcde + 32'd4 : $urandom;
            imem_gnt = ($urandom % 2) == 0;
            if (m_out) begin
                imem_rvalid = ($urandom % 3) == 0;
                imem_rdata = wordof(m_gaddr);
            end else begin
                imem_rvalid = ($urandom % 8) == 0;
                imem_rdata = $urandom;
            end
            checkpointdone = ($urandom % 20) == 0;
            poweron = ($urandom % 25) == 0;
            if (($urandom % 200) == 0) pulse_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
